hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core; it sits beside the forwarding unit.
- Forwarding resolves ALU-to-ALU hazards; this block handles everything forwarding cannot:
  - load-use bubbles,
  - instruction/data memory miss freezes,
  - EX-stage control-flow redirects, including a redirect that lands while an I-fetch is outstanding.
- It drives the per-stage pipeline-register load/flush enables and the PC redirect select, and keeps stall/flush performance counters.

---
 rtl/hazard_stall_controller.sv | 188 ++++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use bubbles,
// memory-miss freezes and EX redirects (including redirects racing an I-fetch).
module hazard_stall_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ID_rs1_i,
  input  logic [4:0]           ID_rs2_i,
  input  logic                 ID_uses_rs1_i,
  input  logic                 ID_uses_rs2_i,
  input  logic [4:0]           ID_EX_rd_i,
  input  logic                 ID_EX_is_load_i,
  input  logic                 EX_redirect_i,
  input  logic [31:0]          EX_target_i,
  input  logic                 imem_req_i,
  input  logic                 imem_resp_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_resp_i,
  output logic                 pc_load_o,
  output logic                 IF_ID_load_o,
  output logic                 ID_EX_load_o,
  output logic                 EX_MEM_load_o,
  output logic                 MEM_WB_load_o,
  output logic                 IF_ID_flush_o,
  output logic                 ID_EX_flush_o,
  output logic                 pc_redirect_o,
  output logic [31:0]          pc_target_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_KILL = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [31:0]          tgt_r;
  logic [31:0]          tgt_nxt_s;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;

  logic mem_stall_s;
  logic fetch_stall_s;
  logic load_use_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic flush_inc_s;

  logic        pc_load_s;
  logic        if_id_load_s;
  logic        id_ex_load_s;
  logic        ex_mem_load_s;
  logic        mem_wb_load_s;
  logic        if_id_flush_s;
  logic        id_ex_flush_s;
  logic        pc_redirect_s;
  logic [31:0] pc_target_s;

  // Counters stick at all-ones so long runs never wrap back to small values.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] value,
    input logic                 en
  );
    logic [CNT_WIDTH-1:0] result;
    if (en && !(&value)) begin
      result = value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
    return result;
  endfunction

  assign mem_stall_s   = dmem_req_i & ~dmem_resp_i;
  assign fetch_stall_s = imem_req_i & ~imem_resp_i;
  assign rs1_hit_s     = ID_uses_rs1_i & (ID_EX_rd_i == ID_rs1_i);
  assign rs2_hit_s     = ID_uses_rs2_i & (ID_EX_rd_i == ID_rs2_i);
  assign load_use_s    = ID_EX_is_load_i & (|ID_EX_rd_i) & (rs1_hit_s | rs2_hit_s);

  // Prioritised stage-enable, flush and next-state decode for the current cycle.
  always_comb begin
    pc_load_s     = 1'b1;
    if_id_load_s  = 1'b1;
    id_ex_load_s  = 1'b1;
    ex_mem_load_s = 1'b1;
    mem_wb_load_s = 1'b1;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    pc_redirect_s = 1'b0;
    pc_target_s   = EX_target_i;
    state_nxt_s   = state_r;
    tgt_nxt_s     = tgt_r;
    flush_inc_s   = 1'b0;

    if (!rst) begin
      pc_load_s     = 1'b0;
      if_id_load_s  = 1'b0;
      id_ex_load_s  = 1'b0;
      ex_mem_load_s = 1'b0;
      mem_wb_load_s = 1'b0;
      pc_target_s   = 32'd0;
      state_nxt_s   = RUN;
    end else if (mem_stall_s) begin
      // EX is frozen, so a pending redirect or load-use simply waits it out.
      pc_load_s     = 1'b0;
      if_id_load_s  = 1'b0;
      id_ex_load_s  = 1'b0;
      ex_mem_load_s = 1'b0;
      mem_wb_load_s = 1'b0;
      if ((state_r == FETCH_WAIT) || (state_r == FETCH_KILL)) begin
        state_nxt_s = state_r;
      end else begin
        state_nxt_s = MEM_WAIT;
      end
    end else if (state_r == FETCH_KILL) begin
      id_ex_flush_s = 1'b1;
      if (imem_resp_i) begin
        pc_load_s     = 1'b1;
        if_id_load_s  = 1'b1;
        pc_redirect_s = 1'b1;
        pc_target_s   = tgt_r;
        if_id_flush_s = 1'b1;
        flush_inc_s   = 1'b1;
        state_nxt_s   = RUN;
      end else begin
        pc_load_s     = 1'b0;
        if_id_load_s  = 1'b0;
        state_nxt_s   = FETCH_KILL;
      end
    end else if (EX_redirect_i && fetch_stall_s) begin
      // The in-flight fetch is on the wrong path; park the target until it lands.
      tgt_nxt_s     = EX_target_i;
      pc_load_s     = 1'b0;
      if_id_load_s  = 1'b0;
      id_ex_flush_s = 1'b1;
      state_nxt_s   = FETCH_KILL;
    end else if (EX_redirect_i) begin
      pc_redirect_s = 1'b1;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
      flush_inc_s   = 1'b1;
      state_nxt_s   = RUN;
    end else if (load_use_s || fetch_stall_s) begin
      pc_load_s     = 1'b0;
      if_id_load_s  = 1'b0;
      id_ex_flush_s = 1'b1;
      if (fetch_stall_s) begin
        state_nxt_s = FETCH_WAIT;
      end else begin
        state_nxt_s = RUN;
      end
    end else begin
      state_nxt_s = RUN;
    end
  end

  // State, parked redirect target and performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      tgt_r       <= 32'd0;
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      flush_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      tgt_r       <= tgt_nxt_s;
      stall_cnt_r <= sat_inc(stall_cnt_r, ~pc_load_s);
      flush_cnt_r <= sat_inc(flush_cnt_r, flush_inc_s);
    end
  end

  assign pc_load_o     = pc_load_s;
  assign IF_ID_load_o  = if_id_load_s;
  assign ID_EX_load_o  = id_ex_load_s;
  assign EX_MEM_load_o = ex_mem_load_s;
  assign MEM_WB_load_o = mem_wb_load_s;
  assign IF_ID_flush_o = if_id_flush_s;
  assign ID_EX_flush_o = id_ex_flush_s;
  assign pc_redirect_o = pc_redirect_s;
  assign pc_target_o   = pc_target_s;
  assign stall_cnt_o   = stall_cnt_r;
  assign flush_cnt_o   = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller; a second instance
// with 2-bit counters exercises counter saturation.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs1_i, ID_rs2_i, ID_EX_rd_i;
  logic        ID_uses_rs1_i, ID_uses_rs2_i, ID_EX_is_load_i;
  logic        EX_redirect_i;
  logic [31:0] EX_target_i;
  logic        imem_req_i, imem_resp_i, dmem_req_i, dmem_resp_i;

  logic        pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o;
  logic        IF_ID_flush_o, ID_EX_flush_o, pc_redirect_o;
  logic [31:0] pc_target_o, stall_cnt_o, flush_cnt_o;

  logic        s_pc_load, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load;
  logic        s_if_id_flush, s_id_ex_flush, s_pc_redirect;
  logic [31:0] s_pc_target;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [7:0]  ctl;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] CTL_RESET  = 8'b00000000;
  localparam logic [7:0] CTL_RUN    = 8'b11111000;
  localparam logic [7:0] CTL_BUBBLE = 8'b00111010;
  localparam logic [7:0] CTL_FREEZE = 8'b00000000;
  localparam logic [7:0] CTL_REDIR  = 8'b11111111;

  assign ctl = {pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
                IF_ID_flush_o, ID_EX_flush_o, pc_redirect_o};

  always #5 clk = ~clk;

  hazard_stall_controller #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
    .ID_EX_rd_i(ID_EX_rd_i), .ID_EX_is_load_i(ID_EX_is_load_i),
    .EX_redirect_i(EX_redirect_i), .EX_target_i(EX_target_i),
    .imem_req_i(imem_req_i), .imem_resp_i(imem_resp_i),
    .dmem_req_i(dmem_req_i), .dmem_resp_i(dmem_resp_i),
    .pc_load_o(pc_load_o), .IF_ID_load_o(IF_ID_load_o), .ID_EX_load_o(ID_EX_load_o),
    .EX_MEM_load_o(EX_MEM_load_o), .MEM_WB_load_o(MEM_WB_load_o),
    .IF_ID_flush_o(IF_ID_flush_o), .ID_EX_flush_o(ID_EX_flush_o),
    .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  hazard_stall_controller #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
    .ID_EX_rd_i(ID_EX_rd_i), .ID_EX_is_load_i(ID_EX_is_load_i),
    .EX_redirect_i(EX_redirect_i), .EX_target_i(EX_target_i),
    .imem_req_i(imem_req_i), .imem_resp_i(imem_resp_i),
    .dmem_req_i(dmem_req_i), .dmem_resp_i(dmem_resp_i),
    .pc_load_o(s_pc_load), .IF_ID_load_o(s_if_id_load), .ID_EX_load_o(s_id_ex_load),
    .EX_MEM_load_o(s_ex_mem_load), .MEM_WB_load_o(s_mem_wb_load),
    .IF_ID_flush_o(s_if_id_flush), .ID_EX_flush_o(s_id_ex_flush),
    .pc_redirect_o(s_pc_redirect), .pc_target_o(s_pc_target),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ID_rs1_i = 5'd0; ID_rs2_i = 5'd0; ID_EX_rd_i = 5'd0;
    ID_uses_rs1_i = 1'b0; ID_uses_rs2_i = 1'b0; ID_EX_is_load_i = 1'b0;
    EX_redirect_i = 1'b0; EX_target_i = 32'd0;
    imem_req_i = 1'b0; imem_resp_i = 1'b0; dmem_req_i = 1'b0; dmem_resp_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    EX_target_i = 32'h0000_0abc;
    settle();
    checks++;
    if (ctl !== CTL_RESET) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RESET); end
    checks++;
    if (pc_target_o !== 32'd0) begin errors++; $display("FAIL reset_target got=%h exp=0", pc_target_o); end
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
    end
    tick();
    rst = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, CTL_RUN); end
    checks++;
    if (pc_target_o !== 32'h0000_0abc) begin errors++; $display("FAIL post_reset_target got=%h exp=abc", pc_target_o); end
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_is_load_i = 1'b1; ID_EX_rd_i = 5'd5;
    ID_rs1_i = 5'd3; ID_uses_rs1_i = 1'b1;
    ID_rs2_i = 5'd5; ID_uses_rs2_i = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL lu_bubble got=%b exp=%b", ctl, CTL_BUBBLE); end
    tick();
    ID_EX_is_load_i = 1'b0;
    settle();
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_after got=%b exp=%b", ctl, CTL_RUN); end
    checks++;
    if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt_o); end
    tick();
    ID_EX_is_load_i = 1'b1; ID_EX_rd_i = 5'd0; ID_rs2_i = 5'd0;
    settle();
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_x0 got=%b exp=%b", ctl, CTL_RUN); end
    tick();
    ID_EX_rd_i = 5'd9; ID_rs2_i = 5'd9; ID_uses_rs2_i = 1'b0;
    settle();
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_unused_rs2 got=%b exp=%b", ctl, CTL_RUN); end
    tick();
    ID_rs1_i = 5'd9;
    settle();
    checks++;
    if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, CTL_BUBBLE); end
    tick();
    clear_inputs();
    settle();
    checks++;
    if (stall_cnt_o !== 32'd2) begin errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt_o); end
  endtask

  task automatic test_mem_stall_redirect();
    do_reset();
    dmem_req_i = 1'b1; dmem_resp_i = 1'b0;
    EX_redirect_i = 1'b1; EX_target_i = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (ctl !== CTL_FREEZE) begin errors++; $display("FAIL mem_freeze[%0d] got=%b exp=%b", i, ctl, CTL_FREEZE); end
      tick();
    end
    dmem_resp_i = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_REDIR || pc_target_o !== 32'h0000_0200) begin
      errors++; $display("FAIL mem_release_redir got=%b/%h exp=%b/200", ctl, pc_target_o, CTL_REDIR);
    end
    checks++;
    if (stall_cnt_o !== 32'd4) begin errors++; $display("FAIL mem_stall_cnt got=%0d exp=4", stall_cnt_o); end
    tick();
    clear_inputs();
    settle();
    checks++;
    if (flush_cnt_o !== 32'd1) begin errors++; $display("FAIL mem_flush_cnt got=%0d exp=1", flush_cnt_o); end
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL mem_after got=%b exp=%b", ctl, CTL_RUN); end
  endtask

  task automatic test_fetch_kill();
    do_reset();
    EX_redirect_i = 1'b1; EX_target_i = 32'h0000_0100; imem_req_i = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL fk_entry got=%b exp=%b", ctl, CTL_BUBBLE); end
    tick();
    EX_redirect_i = 1'b0; EX_target_i = 32'hdead_beef;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL fk_wait[%0d] got=%b exp=%b", i, ctl, CTL_BUBBLE); end
      tick();
    end
    imem_resp_i = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_REDIR || pc_target_o !== 32'h0000_0100) begin
      errors++; $display("FAIL fk_resp got=%b/%h exp=%b/100", ctl, pc_target_o, CTL_REDIR);
    end
    tick();
    clear_inputs();
    settle();
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL fk_after got=%b exp=%b", ctl, CTL_RUN); end
    checks++;
    if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd4) begin
      errors++; $display("FAIL fk_cnt got=%0d/%0d exp=4/1", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_fetch_kill_mem_stall();
    do_reset();
    EX_redirect_i = 1'b1; EX_target_i = 32'h0000_0100; imem_req_i = 1'b1;
    tick();
    EX_redirect_i = 1'b0; EX_target_i = 32'h0000_0444;
    settle();
    checks++;
    if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL fkm_kill got=%b exp=%b", ctl, CTL_BUBBLE); end
    tick();
    dmem_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) imem_resp_i = 1'b1;
      settle();
      checks++;
      if (ctl !== CTL_FREEZE) begin errors++; $display("FAIL fkm_freeze[%0d] got=%b exp=%b", i, ctl, CTL_FREEZE); end
      tick();
    end
    dmem_resp_i = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_REDIR || pc_target_o !== 32'h0000_0100) begin
      errors++; $display("FAIL fkm_resp got=%b/%h exp=%b/100", ctl, pc_target_o, CTL_REDIR);
    end
    tick();
    clear_inputs();
    settle();
    checks++;
    if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd4) begin
      errors++; $display("FAIL fkm_cnt got=%0d/%0d exp=4/1", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_redirect_vs_load_use();
    do_reset();
    EX_redirect_i = 1'b1; EX_target_i = 32'h0000_0300;
    ID_EX_is_load_i = 1'b1; ID_EX_rd_i = 5'd7; ID_rs1_i = 5'd7; ID_uses_rs1_i = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_REDIR || pc_target_o !== 32'h0000_0300) begin
      errors++; $display("FAIL rlu_redir got=%b/%h exp=%b/300", ctl, pc_target_o, CTL_REDIR);
    end
    tick();
    clear_inputs();
    settle();
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL rlu_after got=%b exp=%b", ctl, CTL_RUN); end
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd1) begin
      errors++; $display("FAIL rlu_cnt got=%0d/%0d exp=0/1", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    EX_redirect_i = 1'b1; EX_target_i = 32'h0000_0100; imem_req_i = 1'b1;
    tick();
    EX_redirect_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RESET || pc_target_o !== 32'd0) begin
      errors++; $display("FAIL ar_outputs got=%b/%h exp=%b/0", ctl, pc_target_o, CTL_RESET);
    end
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      errors++; $display("FAIL ar_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
    end
    tick();
    clear_inputs();
    rst = 1'b1;
    settle();
    checks++;
    if (ctl !== CTL_RUN) begin errors++; $display("FAIL ar_state_run got=%b exp=%b", ctl, CTL_RUN); end
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      errors++; $display("FAIL ar_cnt_after got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req_i = 1'b1;
    repeat (6) tick();
    dmem_req_i = 1'b0;
    EX_redirect_i = 1'b1;
    repeat (5) tick();
    clear_inputs();
    settle();
    checks++;
    if (s_stall_cnt !== 2'd3 || s_flush_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_small got=%0d/%0d exp=3/3", s_stall_cnt, s_flush_cnt);
    end
    checks++;
    if (stall_cnt_o !== 32'd6 || flush_cnt_o !== 32'd5) begin
      errors++; $display("FAIL sat_wide got=%0d/%0d exp=6/5", stall_cnt_o, flush_cnt_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mem_stall_redirect();
    test_fetch_kill();
    test_fetch_kill_mem_stall();
    test_redirect_vs_load_use();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
